// File: rtl/dendrite_accum.sv
// Dendrite accumulator: serial fire stream -> 1-cycle read-modify-write of the per-neuron charge RAM,
// once-per-timestep activity reporting through a small FIFO, and a full-RAM zero sweep on clear.

module dendrite_accum_chk #(
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             reset_n,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] fifo_cnt,
  input logic [CNT_W-1:0] fifo_max
);
  // The ready rule must reserve a slot for every fire in flight, so a push never meets a full FIFO.
  assert property (@(posedge clk) disable iff (!reset_n) !(push && (fifo_cnt == fifo_max)))
    else $error("activity FIFO overflow");

  assert property (@(posedge clk) disable iff (!reset_n) !(pop && (fifo_cnt == '0)))
    else $error("activity FIFO underflow");
endmodule

module dendrite_accum #(
  parameter int NUM_NEURONS    = 256,
  parameter int ADDR_W         = 8,
  parameter int CHARGE_W       = 16,
  parameter int ACT_FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                clear,
  output logic                clear_done,
  input  logic [ADDR_W-1:0]   dend_addr,
  input  logic [8:0]          dend_charge,
  input  logic                dend_vld,
  output logic                dend_rdy,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_rd_addr,
  input  logic [CHARGE_W-1:0] ram_rd_data,
  output logic                ram_wr_en,
  output logic [ADDR_W-1:0]   ram_wr_addr,
  output logic [CHARGE_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0]   act_addr,
  output logic                act_vld,
  input  logic                act_rdy
);
  localparam int PTR_W = (ACT_FIFO_DEPTH > 1) ? $clog2(ACT_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic                  enter_clear_s;
  logic                  sweep_last_s;
  logic                  clear_pend_r;
  logic                  clear_done_r;
  logic [ADDR_W-1:0]     sweep_cnt_r;

  logic                  s1_vld_r;
  logic [ADDR_W-1:0]     s1_addr_r;
  logic [8:0]            s1_charge_r;
  logic                  fwd_vld_r;
  logic [ADDR_W-1:0]     fwd_addr_r;
  logic [CHARGE_W-1:0]   fwd_data_r;

  logic [NUM_NEURONS-1:0] bitmap_r;
  logic [ADDR_W-1:0]     fifo_mem_r [ACT_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      fifo_cnt_r;

  logic                  rdy_s;
  logic                  accept_s;
  logic [CHARGE_W-1:0]   op_s;
  logic [CHARGE_W:0]     sum_s;
  logic [CHARGE_W-1:0]   sat_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_empty_s;

  function automatic logic [CHARGE_W-1:0] sat_sum(input logic [CHARGE_W:0] s);
    logic [CHARGE_W-1:0] r;
    if (s[CHARGE_W] != s[CHARGE_W-1]) begin
      r = s[CHARGE_W] ? {1'b1, {(CHARGE_W-1){1'b0}}} : {1'b0, {(CHARGE_W-1){1'b1}}};
    end else begin
      r = s[CHARGE_W-1:0];
    end
    return r;
  endfunction

  // Fire acceptance, RMW datapath and FIFO handshake.
  always_comb begin
    fifo_empty_s = (fifo_cnt_r == '0);
    rdy_s = (state_r == ST_RUN) && enable && !clear_pend_r &&
            (({1'b0, fifo_cnt_r} + {{CNT_W{1'b0}}, s1_vld_r}) < (CNT_W+1)'(ACT_FIFO_DEPTH));
    accept_s = dend_vld && rdy_s;
    if (fwd_vld_r && (fwd_addr_r == s1_addr_r)) begin
      op_s = fwd_data_r;
    end else begin
      op_s = ram_rd_data;
    end
    sum_s  = {op_s[CHARGE_W-1], op_s} + {{(CHARGE_W-8){s1_charge_r[8]}}, s1_charge_r};
    sat_s  = sat_sum(sum_s);
    push_s = s1_vld_r && !bitmap_r[s1_addr_r];
    pop_s  = !fifo_empty_s && act_rdy;
  end

  // Output ports.
  always_comb begin
    dend_rdy    = rdy_s;
    ram_rd_en   = accept_s;
    ram_rd_addr = accept_s ? dend_addr : {ADDR_W{1'b0}};
    ram_wr_en   = 1'b0;
    ram_wr_addr = {ADDR_W{1'b0}};
    ram_wr_data = {CHARGE_W{1'b0}};
    if (state_r == ST_CLEAR) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = sweep_cnt_r;
    end else if (s1_vld_r) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = s1_addr_r;
      ram_wr_data = sat_s;
    end else begin
      ram_wr_en   = 1'b0;
    end
    act_vld    = !fifo_empty_s;
    act_addr   = fifo_empty_s ? {ADDR_W{1'b0}} : fifo_mem_r[rd_ptr_r];
    clear_done = clear_done_r;
  end

  // Next-state logic; a clear waits for the pipeline and the FIFO to drain.
  always_comb begin
    state_s       = state_r;
    enter_clear_s = 1'b0;
    sweep_last_s  = (sweep_cnt_r == ADDR_W'(NUM_NEURONS-1));
    case (state_r)
      ST_IDLE, ST_RUN: begin
        if (clear_pend_r && !s1_vld_r && fifo_empty_s) begin
          state_s       = ST_CLEAR;
          enter_clear_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_CLEAR: begin
        if (sweep_last_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, clear bookkeeping and sweep counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      clear_pend_r <= 1'b0;
      clear_done_r <= 1'b0;
      sweep_cnt_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r      <= state_s;
      clear_pend_r <= clear || (clear_pend_r && !enter_clear_s);
      clear_done_r <= (state_r == ST_CLEAR) && sweep_last_s;
      if (state_r == ST_CLEAR) begin
        sweep_cnt_r <= sweep_last_s ? {ADDR_W{1'b0}} : sweep_cnt_r + ADDR_W'(1);
      end else begin
        sweep_cnt_r <= {ADDR_W{1'b0}};
      end
    end
  end

  // S1 stage and write-forwarding register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_r    <= 1'b0;
      s1_addr_r   <= {ADDR_W{1'b0}};
      s1_charge_r <= 9'd0;
      fwd_vld_r   <= 1'b0;
      fwd_addr_r  <= {ADDR_W{1'b0}};
      fwd_data_r  <= {CHARGE_W{1'b0}};
    end else begin
      s1_vld_r  <= accept_s;
      fwd_vld_r <= s1_vld_r;
      if (accept_s) begin
        s1_addr_r   <= dend_addr;
        s1_charge_r <= dend_charge;
      end
      if (s1_vld_r) begin
        fwd_addr_r <= s1_addr_r;
        fwd_data_r <= sat_s;
      end
    end
  end

  // Touched-neuron bitmap: set on first write, zeroed by the sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitmap_r <= {NUM_NEURONS{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      bitmap_r[sweep_cnt_r] <= 1'b0;
    end else if (push_s) begin
      bitmap_r[s1_addr_r] <= 1'b1;
    end
  end

  // Activity FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Activity FIFO storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ACT_FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {ADDR_W{1'b0}};
      end
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= s1_addr_r;
    end
  end

  dendrite_accum_chk #(.CNT_W(CNT_W)) u_chk (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_s),
    .pop      (pop_s),
    .fifo_cnt (fifo_cnt_r),
    .fifo_max (CNT_W'(ACT_FIFO_DEPTH))
  );
endmodule

// File: tb/tb_dendrite_accum.sv
// Bench for dendrite_accum: read-first RAM model, per-cycle comparison against an abstract
// charge/activity model, and directed scenarios with literal expectations.

module tb_dendrite_accum;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        clear;
  logic        clear_done;
  logic [7:0]  dend_addr;
  logic [8:0]  dend_charge;
  logic        dend_vld;
  logic        dend_rdy;
  logic        ram_rd_en;
  logic [7:0]  ram_rd_addr;
  logic [15:0] ram_rd_data;
  logic        ram_wr_en;
  logic [7:0]  ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic [7:0]  act_addr;
  logic        act_vld;
  logic        act_rdy;

  int tests = 0;
  int fails = 0;

  dendrite_accum dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .clear_done(clear_done),
    .dend_addr(dend_addr), .dend_charge(dend_charge), .dend_vld(dend_vld), .dend_rdy(dend_rdy),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .act_addr(act_addr), .act_vld(act_vld), .act_rdy(act_rdy)
  );

  always #5 clk = ~clk;

  // Charge RAM, read-first, 1-cycle read latency.
  logic [15:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
    if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Abstract model state.
  int charge_m [256];
  bit seen_m [256];
  bit acc_p = 0;
  int acc_a, acc_c;
  bit act_p = 0;
  int act_pa;
  int act_q[$];
  int wlog[$];
  int alog[$];
  int clr_idx = 0;
  int sweep_writes = 0;
  bit done_exp = 0;
  int acc_cnt = 0;
  int exp_w, got_w;

  always @(negedge clk) begin
    if (!reset_n) begin
      acc_p = 0; act_p = 0; act_q.delete(); clr_idx = 0; done_exp = 0;
      for (int i = 0; i < 256; i++) seen_m[i] = 0;
    end else begin
      chk("clear_done", clear_done, done_exp);
      done_exp = 0;
      if (act_p) begin act_q.push_back(act_pa); act_p = 0; end
      if (acc_p) begin
        exp_w = sat(charge_m[acc_a] + acc_c);
        charge_m[acc_a] = exp_w;
        got_w = $signed(ram_wr_data);
        chk("wr_en", ram_wr_en, 1);
        chk("wr_addr", ram_wr_addr, acc_a);
        chk("wr_data", got_w, exp_w);
        wlog.push_back(got_w);
        if (!seen_m[acc_a]) begin seen_m[acc_a] = 1; act_p = 1; act_pa = acc_a; end
        acc_p = 0;
      end else if (ram_wr_en) begin
        chk("clr_addr", ram_wr_addr, clr_idx);
        chk("clr_data", ram_wr_data, 0);
        chk("clr_fifo_empty", act_vld, 0);
        charge_m[ram_wr_addr] = 0;
        seen_m[ram_wr_addr] = 0;
        sweep_writes++;
        if (clr_idx == 255) begin done_exp = 1; clr_idx = 0; end
        else clr_idx++;
      end else if (clr_idx != 0) begin
        chk("clr_gap", ram_wr_en, 1);
      end
      chk("act_vld", act_vld, act_q.size() > 0);
      if (act_vld && act_q.size() > 0) begin
        chk("act_addr", act_addr, act_q[0]);
        if (act_rdy) begin alog.push_back(act_addr); void'(act_q.pop_front()); end
      end
      chk("rd_en", ram_rd_en, dend_vld && dend_rdy);
      if (dend_vld && dend_rdy) begin
        chk("rd_addr", ram_rd_addr, dend_addr);
        acc_p = 1; acc_a = dend_addr; acc_c = $signed(dend_charge); acc_cnt++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int c);
    int n = 0;
    dend_vld = 1'b1; dend_addr = 8'(a); dend_charge = 9'(c);
    @(negedge clk);
    while (!dend_rdy && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("send_timeout", n, 0);
    @(posedge clk); #1;
    dend_vld = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!clear_done && n < 3000);
    chk(nm, clear_done, 1);
    chk({nm, "_rdy"}, dend_rdy, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_clear(input string nm);
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    wait_done(nm);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_dend_rdy"}, dend_rdy, 0);
    chk({nm, "_rd_en"}, ram_rd_en, 0);
    chk({nm, "_rd_addr"}, ram_rd_addr, 0);
    chk({nm, "_wr_en"}, ram_wr_en, 0);
    chk({nm, "_wr_addr"}, ram_wr_addr, 0);
    chk({nm, "_wr_data"}, ram_wr_data, 0);
    chk({nm, "_act_vld"}, act_vld, 0);
    chk({nm, "_act_addr"}, act_addr, 0);
    chk({nm, "_clear_done"}, clear_done, 0);
  endtask

  initial begin
    int n10;
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; dend_vld = 1'b0;
    dend_addr = 8'd0; dend_charge = 9'd0; act_rdy = 1'b1;
    #12 check_zero("reset");
    #10 reset_n = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    dend_vld = 1'b1;
    repeat (3) begin @(negedge clk); chk("idle_rdy", dend_rdy, 0); end
    @(posedge clk); #1; dend_vld = 1'b0;

    // 1: first sweep
    do_clear("t1_done");
    chk("t1_sweep_writes", sweep_writes, 256);

    // 2: back-to-back forwarding on one address
    wlog.delete(); alog.delete();
    send(10, 5); send(10, 7); send(10, -3); idle(4);
    chk("t2_nwr", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("t2_w0", wlog[0], 5); chk("t2_w1", wlog[1], 12); chk("t2_w2", wlog[2], 9);
    end
    chk("t2_nact", alog.size(), 1);
    if (alog.size() == 1) chk("t2_act", alog[0], 10);

    // 3: saturation both ways
    wlog.delete(); alog.delete();
    for (int i = 0; i < 260; i++) send(3, 127);
    idle(3);
    chk("t3_pos_n", wlog.size(), 260);
    if (wlog.size() == 260) begin
      chk("t3_f258", wlog[257], 32766); chk("t3_f259", wlog[258], 32767);
      chk("t3_f260", wlog[259], 32767);
    end
    wlog.delete();
    for (int i = 0; i < 257; i++) send(4, -128);
    idle(3);
    chk("t3_neg_n", wlog.size(), 257);
    if (wlog.size() == 257) begin
      chk("t3_f255", wlog[254], -32640); chk("t3_f256", wlog[255], -32768);
      chk("t3_f257", wlog[256], -32768);
    end
    chk("t3_nact", alog.size(), 2);
    if (alog.size() == 2) begin chk("t3_a0", alog[0], 3); chk("t3_a1", alog[1], 4); end

    // 4: backpressure from the activity FIFO
    do_clear("t4_done");
    alog.delete(); act_rdy = 1'b0; n10 = acc_cnt;
    fork
      begin for (int i = 1; i <= 6; i++) send(i, 1); end
      begin
        repeat (8) @(negedge clk);
        chk("t4_rdy_low", dend_rdy, 0);
        chk("t4_accepted", acc_cnt - n10, 4);
        chk("t4_head", act_addr, 1);
        @(posedge clk); #1 act_rdy = 1'b1;
      end
    join
    idle(6);
    chk("t4_nact", alog.size(), 6);
    for (int i = 0; i < 6; i++) if (i < alog.size()) chk("t4_order", alog[i], i + 1);

    // 5: clear arriving mid-stream
    alog.delete();
    send(10, 1); send(10, 1); idle(4);
    act_rdy = 1'b0;
    fork
      begin send(20, 1); send(21, 1); send(22, 1); end
      begin
        @(posedge clk); @(posedge clk); #1 clear = 1'b1;
        @(negedge clk); chk("t5_rdy_before", dend_rdy, 1);
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk); chk("t5_rdy_drop", dend_rdy, 0); chk("t5_fifo_busy", act_vld, 1);
      end
    join
    idle(3);
    chk("t5_held", dend_rdy, 0);
    act_rdy = 1'b1;
    wait_done("t5_done");
    send(10, 2); idle(4);
    chk("t5_nact", alog.size(), 5);
    if (alog.size() == 5) begin
      chk("t5_a0", alog[0], 10); chk("t5_a1", alog[1], 20); chk("t5_a2", alog[2], 21);
      chk("t5_a3", alog[3], 22); chk("t5_a4", alog[4], 10);
    end

    // 6: asynchronous reset mid-stream
    act_rdy = 1'b0; dend_addr = 8'd30; dend_charge = 9'd1; dend_vld = 1'b1;
    repeat (3) @(posedge clk);
    #3 chk("t6_act_pre", act_vld, 1);
    reset_n = 1'b0;
    #1 check_zero("t6");
    @(posedge clk); @(posedge clk); #3 reset_n = 1'b1;
    repeat (4) begin @(negedge clk); chk("t6_idle_rdy", dend_rdy, 0); end
    dend_vld = 1'b0; act_rdy = 1'b1;
    @(posedge clk); #1;
    do_clear("t6_done");
    wlog.delete(); alog.delete();
    send(7, 3); idle(4);
    chk("t6_nwr", wlog.size(), 1);
    if (wlog.size() == 1) chk("t6_w", wlog[0], 3);
    chk("t6_nact", alog.size(), 1);
    if (alog.size() == 1) chk("t6_a", alog[0], 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
